// File: rtl/rvfi_channel_serializer.sv
// Buffers up to NRET RVFI retirements per cycle and replays them one per cycle, oldest first.
// Optional order-sequence checking is enabled with RVFI_SERIALIZER_ORDER_CHECK_EN.
module rvfi_channel_serializer #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 64,
    localparam int unsigned CW   = (NRET > 1) ? $clog2(NRET) : 1,
    localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRET-1:0]   in_valid,
    input  logic [NRET*64-1:0] in_order,
    input  logic [NRET*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_order,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_chan,
    output logic [CNTW-1:0]   count,
    output logic              overflow,
    output logic              order_err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(NRET + 1);

    logic [63:0]   mem_order [DEPTH];
    logic [DW-1:0] mem_data  [DEPTH];
    logic [CW-1:0] mem_chan  [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [NW-1:0]   npush;
    logic [PW-1:0]   slot_idx [NRET];
    logic            pop, accept;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_order = mem_order[rd_ptr_q];
    assign out_data  = mem_data[rd_ptr_q];
    assign out_chan  = mem_chan[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Each valid channel lands at wr_ptr plus the number of valid channels below it.
    always_comb begin
        npush = '0;
        for (int i = 0; i < NRET; i++) begin
            slot_idx[i] = PW'((32'(wr_ptr_q) + 32'(npush)) % DEPTH);
            npush       = npush + NW'(in_valid[i]);
        end
    end

    always_comb begin
        accept     = (32'(count_q) + 32'(npush) - 32'(pop)) <= DEPTH;
        rd_ptr_d   = pop ? PW'((32'(rd_ptr_q) + 32'd1) % DEPTH) : rd_ptr_q;
        wr_ptr_d   = accept ? PW'((32'(wr_ptr_q) + 32'(npush)) % DEPTH) : wr_ptr_q;
        count_d    = count_q - CNTW'(pop) + (accept ? CNTW'(npush) : CNTW'(0));
        overflow_d = overflow_q | ((npush != '0) && !accept);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; a rejected group writes nothing.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (in_valid[i]) begin
                    mem_order[slot_idx[i]] <= in_order[i*64 +: 64];
                    mem_data[slot_idx[i]]  <= in_data[i*DW +: DW];
                    mem_chan[slot_idx[i]]  <= CW'(i);
                end
            end
        end
    end

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    logic [63:0] last_order_q, last_order_d;
    logic        seen_q, seen_d, order_err_q, order_err_d;

    always_comb begin
        last_order_d = last_order_q;
        seen_d       = seen_q;
        order_err_d  = order_err_q;
        if (pop) begin
            if (seen_q && (out_order != last_order_q + 64'd1)) order_err_d = 1'b1;
            last_order_d = out_order;
            seen_d       = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_order_q <= '0;
            seen_q       <= 1'b0;
            order_err_q  <= 1'b0;
        end else begin
            last_order_q <= last_order_d;
            seen_q       <= seen_d;
            order_err_q  <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Directed self-checking bench for rvfi_channel_serializer (NRET=2, DEPTH=4, DW=32).
module tb_rvfi_channel_serializer;
    localparam int unsigned NRET  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    localparam bit OrderCheck = 1'b1;
`else
    localparam bit OrderCheck = 1'b0;
`endif

    logic              clock, reset;
    logic [NRET-1:0]   in_valid;
    logic [NRET*64-1:0] in_order;
    logic [NRET*DW-1:0] in_data;
    logic              out_valid, out_ready;
    logic [63:0]       out_order;
    logic [DW-1:0]     out_data;
    logic [0:0]        out_chan;
    logic [2:0]        count;
    logic              overflow, order_err;

    int n_checks = 0;
    int n_fail   = 0;

    rvfi_channel_serializer #(.NRET(NRET), .DEPTH(DEPTH), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_order  (in_order),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_order (out_order),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .count     (count),
        .overflow  (overflow),
        .order_err (order_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic [31:0] d0, input logic [31:0] d1);
        in_valid = v;
        in_order = {o1, o0};
        in_data  = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 64'd0, 64'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b count=%0d ovf=%b oerr=%b, want 0/0/0/0",
                     out_valid, count, overflow, order_err);
        end
    endtask

    task automatic test_dual_retire();
        out_ready = 1'b1;
        drive(2'b11, 64'd10, 64'd11, 32'h1111, 32'h2222);
        step();
        idle();
        n_checks++;
        if (count !== 3'd2 || out_valid !== 1'b1 || out_order !== 64'd10 || out_chan !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_first: count=%0d order=%0d chan=%0d, want 2/10/0",
                     count, out_order, out_chan);
        end
        step();
        n_checks++;
        if (count !== 3'd1 || out_order !== 64'd11 || out_chan !== 1'b1 || out_data !== 32'h2222) begin
            n_fail++;
            $display("FAIL dual_second: count=%0d order=%0d chan=%0d data=%h, want 1/11/1/2222",
                     count, out_order, out_chan, out_data);
        end
        step();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_drain: count=%0d valid=%b, want 0/0", count, out_valid);
        end
    endtask

    task automatic test_sparse();
        out_ready = 1'b0;
        drive(2'b10, 64'd99, 64'd5, 32'hDEAD, 32'h0505);
        step();
        idle();
        n_checks++;
        if (count !== 3'd1 || out_chan !== 1'b1 || out_order !== 64'd5 || out_data !== 32'h0505) begin
            n_fail++;
            $display("FAIL sparse: count=%0d chan=%0d order=%0d data=%h, want 1/1/5/0505",
                     count, out_chan, out_order, out_data);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL sparse_drain: count=%0d, want 0", count);
        end
    endtask

    // Pointers sit at 3 here, so the pair straddles slots 3 and 0.
    task automatic test_wrap();
        out_ready = 1'b0;
        drive(2'b11, 64'd20, 64'd21, 32'hA5A5_0001, 32'hA5A5_0002);
        step();
        idle();
        n_checks++;
        if (out_order !== 64'd20 || out_data !== 32'hA5A5_0001 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_first: order=%0d data=%h count=%0d, want 20/a5a50001/2",
                     out_order, out_data, count);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_order !== 64'd21 || out_data !== 32'hA5A5_0002 || out_chan !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_second: order=%0d data=%h chan=%0d, want 21/a5a50002/1",
                     out_order, out_data, out_chan);
        end
        step();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        drive(2'b11, 64'd30, 64'd31, 32'd0, 32'd0);
        step();
        drive(2'b11, 64'd32, 64'd33, 32'd0, 32'd0);
        step();
        drive(2'b11, 64'd34, 64'd35, 32'd0, 32'd0);
        step();
        idle();
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drop: count=%0d ovf=%b, want 4/1", count, overflow);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_order !== 64'(30 + k)) begin
                n_fail++;
                $display("FAIL overflow_drain%0d: valid=%b order=%0d, want 1/%0d",
                         k, out_valid, out_order, 30 + k);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_after: valid=%b count=%0d ovf=%b, want 0/0/1",
                     out_valid, count, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(2'b11, 64'd50, 64'd51, 32'd0, 32'd0);
        step();
        drive(2'b01, 64'd52, 64'd0, 32'd0, 32'd0);
        step();
        idle();
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_fill: count=%0d, want 3", count);
        end
        reset = 1'b1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b count=%0d ovf=%b, want 0/0/0",
                     out_valid, count, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_release: valid=%b count=%0d, want 0/0", out_valid, count);
        end
        drive(2'b01, 64'd60, 64'd0, 32'h6060, 32'd0);
        step();
        idle();
        n_checks++;
        if (out_order !== 64'd60 || out_data !== 32'h6060 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL midreset_fresh: order=%0d data=%h count=%0d, want 60/6060/1",
                     out_order, out_data, count);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        drive(2'b11, 64'd40, 64'd41, 32'd0, 32'd0);
        step();
        drive(2'b11, 64'd42, 64'd43, 32'd0, 32'd0);
        step();
        out_ready = 1'b1;
        drive(2'b01, 64'd44, 64'd0, 32'd0, 32'd0);
        step();
        idle();
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || out_order !== 64'd41) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovf=%b order=%0d, want 4/0/41",
                     count, overflow, out_order);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_order !== 64'(41 + k)) begin
                n_fail++;
                $display("FAIL full_drain%0d: order=%0d, want %0d", k, out_order, 41 + k);
            end
            step();
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL full_empty: count=%0d, want 0", count);
        end
    endtask

    task automatic test_order_check();
        do_reset();
        drive(2'b11, 64'd7, 64'd8, 32'd0, 32'd0);
        step();
        drive(2'b01, 64'd10, 64'd0, 32'd0, 32'd0);
        step();
        idle();
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL order_seq_ok: order_err=%b, want 0", order_err);
        end
        step();
        n_checks++;
        if (order_err !== OrderCheck) begin
            n_fail++;
            $display("FAIL order_gap: order_err=%b, want %b", order_err, OrderCheck);
        end
        step();
        n_checks++;
        if (order_err !== OrderCheck) begin
            n_fail++;
            $display("FAIL order_sticky: order_err=%b, want %b", order_err, OrderCheck);
        end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        idle();
        step();
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        step();
        test_reset();
        test_dual_retire();
        test_sparse();
        test_wrap();
        test_overflow();
        test_reset_midstream();
        test_full_push_pop();
        test_order_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
